// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler and a three-field set mode.
// The mode register is exposed on MODE; DAY_CARRY pulses on the midnight rollover.
module bcd_time_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EXT_CLR,
  input  logic       MODE_BTN,
  input  logic       INC_BTN,
  output logic [3:0] BCD_H1,
  output logic [3:0] BCD_H0,
  output logic [3:0] BCD_M1,
  output logic [3:0] BCD_M0,
  output logic [3:0] BCD_S1,
  output logic [3:0] BCD_S0,
  output logic [1:0] MODE,
  output logic       DAY_CARRY
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic          day_carry_q, day_carry_d;
  logic          s_wrap, m_wrap, h_wrap;

  // Two-digit BCD increments: {tens, units} in, {tens, units} out.
  function automatic logic [7:0] inc60(input logic [3:0] t, input logic [3:0] u);
    if (u == 4'd9) return {(t == 4'd5) ? 4'd0 : t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd2 && u == 4'd3) return 8'h00;
    if (u == 4'd9) return {t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  assign s_wrap = (s1_q == 4'd5) && (s0_q == 4'd9);
  assign m_wrap = (m1_q == 4'd5) && (m0_q == 4'd9);
  assign h_wrap = (h1_q == 4'd2) && (h0_q == 4'd3);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      h1_q        <= '0;
      h0_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      s1_q        <= '0;
      s0_q        <= '0;
      day_carry_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      day_carry_q <= day_carry_d;
    end
  end

  // Clear leaves the mode alone; otherwise MODE_BTN cycles the four modes.
  always_comb begin
    mode_d = mode_q;
    if (!EXT_CLR && MODE_BTN) begin
      unique case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        default: mode_d = RUN;
      endcase
    end
  end

  always_comb begin
    presc_d     = presc_q;
    {h1_d, h0_d} = {h1_q, h0_q};
    {m1_d, m0_d} = {m1_q, m0_q};
    {s1_d, s0_d} = {s1_q, s0_q};
    day_carry_d = 1'b0;
    if (EXT_CLR) begin
      presc_d = '0;
      {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = '0;
    end else if (MODE_BTN) begin
      // Any mode change restarts the prescaler, dropping a coincident tick.
      presc_d = '0;
    end else if (mode_q == RUN) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        {s1_d, s0_d} = inc60(s1_q, s0_q);
        if (s_wrap) {m1_d, m0_d} = inc60(m1_q, m0_q);
        if (s_wrap && m_wrap) {h1_d, h0_d} = inc24(h1_q, h0_q);
        day_carry_d = s_wrap && m_wrap && h_wrap;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
      if (INC_BTN) begin
        unique case (mode_q)
          SET_H:   {h1_d, h0_d} = inc24(h1_q, h0_q);
          SET_M:   {m1_d, m0_d} = inc60(m1_q, m0_q);
          default: {s1_d, s0_d} = inc60(s1_q, s0_q);
        endcase
      end
    end
  end

  always_comb begin
    BCD_H1    = h1_q;
    BCD_H0    = h0_q;
    BCD_M1    = m1_q;
    BCD_M0    = m0_q;
    BCD_S1    = s1_q;
    BCD_S0    = s0_q;
    MODE      = mode_q;
    DAY_CARRY = day_carry_q;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter for the watch datapath. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds as six BCD digits in 24-hour format. A three-field set mode lets the user adjust the time from two pre-debounced button pulses. The digits feed the end-of-day detector and the display driver; the detector's clear output returns on `EXT_CLR`.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per 1 Hz tick. Legal range is ≥ 2. Benches use 4.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST_N`  in  1  synchronous reset, active-low.
- `EXT_CLR`  in  1  synchronous clear of the time digits, active-high.
- `MODE_BTN`  in  1  single-cycle pulse that advances the mode.
- `INC_BTN`  in  1  single-cycle pulse that increments the selected field.
- `BCD_H1`  out  4  hours tens digit, range 0–2.
- `BCD_H0`  out  4  hours units digit, range 0–9.
- `BCD_M1`  out  4  minutes tens digit, range 0–5.
- `BCD_M0`  out  4  minutes units digit, range 0–9.
- `BCD_S1`  out  4  seconds tens digit, range 0–5.
- `BCD_S0`  out  4  seconds units digit, range 0–9.
- `MODE`  out  2  mode encoding: 0 = RUN, 1 = SET_H, 2 = SET_M, 3 = SET_S.
- `DAY_CARRY`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover.

## Operation
- Priority, highest first: `RST_N` low, then `EXT_CLR`, then `MODE_BTN`, then `INC_BTN` or tick.
- Reset (`RST_N` = 0):
  - all digits clear to 0;
  - `MODE` = RUN;
  - `DAY_CARRY` = 0;
  - prescaler = 0.
- `EXT_CLR` = 1:
  - all digits clear to 0 and the prescaler clears to 0;
  - `MODE` is unchanged;
  - `DAY_CARRY` = 0;
  - `MODE_BTN` and `INC_BTN` are ignored that cycle.
- Mode state machine, advanced by `MODE_BTN`: RUN → SET_H → SET_M → SET_S → RUN.
  - On `MODE_BTN`, `INC_BTN` is ignored in the same cycle.
- RUN:
  - The prescaler counts 0 … `TICK_DIV`−1.
  - When it equals `TICK_DIV`−1, the next edge sets it to 0 and advances the time by one second.
  - The seconds units digit carries into the seconds tens digit, the minutes, then the hours, with standard BCD carries.
  - Seconds and minutes wrap 59 → 00.
  - Hours wrap 23 → 00. Carries 09 → 10 and 19 → 20 apply.
  - `INC_BTN` is ignored in RUN.
- Rollover: the tick that moves 23:59:59 to 00:00:00 sets `DAY_CARRY` = 1 for exactly one cycle, registered together with the 00:00:00 digits.
- SET_H, SET_M, SET_S:
  - The prescaler is held at 0 and no ticks occur.
  - `INC_BTN` increments only the selected two-digit field, modulo 24 for hours and modulo 60 for minutes and seconds.
  - Set-mode increments never carry into other fields.
  - Set-mode increments never assert `DAY_CARRY`.
- Leaving SET_S for RUN restarts the prescaler from 0.
- All outputs are registered. Digits never take values outside the ranges listed in the interface.

## Timing
- Latency from reset release to the first increment is `TICK_DIV` cycles.
- Steady-state RUN: one increment every `TICK_DIV` cycles.
- `MODE_BTN` or `INC_BTN` sampled at edge n is visible on the outputs after edge n; single-cycle latency.
- `EXT_CLR` asserted in the same cycle as a tick at `TICK_DIV`−1: the clear wins. The result is 00:00:00, and the next tick arrives `TICK_DIV` cycles later.
- `MODE_BTN` arriving in the same cycle as the prescaler reaches `TICK_DIV`−1 in RUN:
  - the mode changes to SET_H;
  - that tick is dropped;
  - the prescaler goes to 0.
- `EXT_CLR` held high continuously: the digits stay at 00:00:00 and the prescaler stays at 0.
- Buttons held high for multiple cycles act once per cycle. Debouncing and edge detection happen upstream.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Reset then RUN: hold `RST_N` low for 2 cycles, release, wait 4 cycles → digits read 00:00:01. After 40 cycles total → 00:00:10.
- Carry chain: set the time to 00:59:59 via set mode, return to RUN, wait 4 cycles → 01:00:00 with `DAY_CARRY` = 0. Repeat from 09:59:59 → 10:00:00.
- Day rollover: set the time to 23:59:59, enter RUN, wait 4 cycles → 00:00:00 with `DAY_CARRY` high for exactly 1 cycle. No tick occurs earlier than 4 cycles after entering RUN.
- Set mode:
  - `MODE_BTN` once → `MODE` = 1;
  - 25 `INC_BTN` pulses → hours = 01, with minutes and seconds unchanged;
  - `MODE_BTN` → `MODE` = 2, then 61 `INC_BTN` pulses → minutes = 01;
  - no digit moves over 20 idle cycles.
- Simultaneous events:
  - `MODE_BTN` and `INC_BTN` in the same cycle while in SET_H → `MODE` = 2 and hours unchanged;
  - `EXT_CLR` on the tick cycle at 12:34:56 → 00:00:00;
  - `EXT_CLR` while `MODE` = 3 → digits cleared and `MODE` stays 3.
- Reset mid-operation: at 15:42:07 in SET_M, drop `RST_N` for 1 cycle → 00:00:00, `MODE` = 0, `DAY_CARRY` = 0. The first tick follows 4 cycles after release.
